// File: rtl/alu_share_arbiter.sv
// Round-robin front end that shares one external combinational ALU between NREQ
// requesters, with valid/ready on both the request and the response side.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for a request; winner is accepted combinationally
// S_EXEC | registered operands presented to the ALU for one cycle
// S_RESP | result held on rsp_* until the owning requester takes it
module alu_share_arbiter #(
   parameter  int NREQ = 2,
   parameter  int XLEN = 32,
   parameter  int OPW  = 4,
   localparam int GW   = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*XLEN-1:0] req_a,
   input  logic [NREQ*XLEN-1:0] req_b,
   input  logic [NREQ*OPW-1:0]  req_op,
   output logic [XLEN-1:0]      alu_a,
   output logic [XLEN-1:0]      alu_b,
   output logic [OPW-1:0]       alu_op,
   input  logic [XLEN-1:0]      alu_result,
   output logic [NREQ-1:0]      rsp_valid,
   output logic [XLEN-1:0]      rsp_data,
   output logic                 rsp_err,
   input  logic [NREQ-1:0]      rsp_ready,
   output logic                 busy,
   output logic [GW-1:0]        grant_id
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam logic [OPW-1:0] OP_LAST = OPW'(9);
   localparam logic [GW-1:0]  LAST_RST = GW'(NREQ - 1);

   state_t            state_q, state_d;
   logic [XLEN-1:0]   a_q, a_d;
   logic [XLEN-1:0]   b_q, b_d;
   logic [OPW-1:0]    op_q, op_d;
   logic [XLEN-1:0]   rsp_data_q, rsp_data_d;
   logic              rsp_err_q, rsp_err_d;
   logic [GW-1:0]     grant_id_q, grant_id_d;
   logic [GW-1:0]     last_grant_q, last_grant_d;

   logic              win_found;
   logic [GW-1:0]     win_idx;
   logic [GW-1:0]     cand_idx;
   int unsigned       cand;

   // Search upward from the slot after the last served requester, wrapping.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = 0;
      cand_idx  = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand     = (int'(last_grant_q) + k) % NREQ;
         cand_idx = GW'(cand);
         if (!win_found && req_valid[cand_idx]) begin
            win_found = 1'b1;
            win_idx   = cand_idx;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      a_d          = a_q;
      b_d          = b_q;
      op_d         = op_q;
      rsp_data_d   = rsp_data_q;
      rsp_err_d    = rsp_err_q;
      grant_id_d   = grant_id_q;
      last_grant_d = last_grant_q;
      req_ready    = '0;
      rsp_valid    = '0;

      case (state_q)
         S_IDLE: begin
            // No handshake may complete on a reset edge.
            if (win_found && rst_n) begin
               req_ready[win_idx] = 1'b1;
               a_d        = req_a[win_idx*XLEN +: XLEN];
               b_d        = req_b[win_idx*XLEN +: XLEN];
               op_d       = req_op[win_idx*OPW +: OPW];
               grant_id_d = win_idx;
               state_d    = S_EXEC;
            end
         end
         S_EXEC: begin
            rsp_err_d  = (op_q > OP_LAST);
            rsp_data_d = (op_q > OP_LAST) ? '0 : alu_result;
            state_d    = S_RESP;
         end
         S_RESP: begin
            if (rst_n) begin
               rsp_valid[grant_id_q] = 1'b1;
            end
            if (rsp_ready[grant_id_q]) begin
               last_grant_d = grant_id_q;
               state_d      = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         a_q          <= '0;
         b_q          <= '0;
         op_q         <= '0;
         rsp_data_q   <= '0;
         rsp_err_q    <= 1'b0;
         grant_id_q   <= '0;
         last_grant_q <= LAST_RST;
      end else begin
         state_q      <= state_d;
         a_q          <= a_d;
         b_q          <= b_d;
         op_q         <= op_d;
         rsp_data_q   <= rsp_data_d;
         rsp_err_q    <= rsp_err_d;
         grant_id_q   <= grant_id_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign alu_a    = a_q;
   assign alu_b    = b_q;
   assign alu_op   = op_q;
   assign rsp_data = rsp_data_q;
   assign rsp_err  = rsp_err_q;
   assign grant_id = grant_id_q;
   assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with two requesters and a behavioural ALU.
module tb_alu_share_arbiter;

   localparam int NREQ = 2;
   localparam int XLEN = 32;
   localparam int OPW  = 4;
   localparam int GW   = 1;

   logic                 clk;
   logic                 rst_n;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*XLEN-1:0] req_a;
   logic [NREQ*XLEN-1:0] req_b;
   logic [NREQ*OPW-1:0]  req_op;
   logic [XLEN-1:0]      alu_a;
   logic [XLEN-1:0]      alu_b;
   logic [OPW-1:0]       alu_op;
   logic [XLEN-1:0]      alu_result;
   logic [NREQ-1:0]      rsp_valid;
   logic [XLEN-1:0]      rsp_data;
   logic                 rsp_err;
   logic [NREQ-1:0]      rsp_ready;
   logic                 busy;
   logic [GW-1:0]        grant_id;

   int n_cmp = 0;
   int n_err = 0;

   alu_share_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .OPW(OPW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .rsp_ready(rsp_ready), .busy(busy), .grant_id(grant_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Undefined opcodes return a non-zero pattern so the DUT's zeroing is visible.
   always_comb begin
      case (alu_op)
         4'd0:    alu_result = alu_a + alu_b;
         4'd1:    alu_result = alu_a - alu_b;
         4'd2:    alu_result = alu_a & alu_b;
         4'd3:    alu_result = alu_a | alu_b;
         4'd4:    alu_result = alu_a ^ alu_b;
         4'd5:    alu_result = alu_a << alu_b[4:0];
         4'd6:    alu_result = alu_a >> alu_b[4:0];
         4'd7:    alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
         4'd8:    alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
         4'd9:    alu_result = {31'd0, alu_a < alu_b};
         default: alu_result = 32'hDEAD_BEEF;
      endcase
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op);
      req_a[i*XLEN +: XLEN] = a;
      req_b[i*XLEN +: XLEN] = b;
      req_op[i*OPW +: OPW]  = op;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      req_valid = 2'b11;
      rsp_ready = 2'b00;
      set_req(0, 32'd1, 32'd2, 4'd0);
      set_req(1, 32'd3, 32'd4, 4'd0);
      repeat (3) tick();
      n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL rst_req_ready got=%b exp=00", req_ready); end
      n_cmp++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL rst_rsp_valid got=%b exp=00", rsp_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%b exp=0", busy); end
      n_cmp++; if ({alu_a, alu_b, alu_op} !== 68'd0) begin n_err++; $display("FAIL rst_alu got=%h/%h/%h exp=0", alu_a, alu_b, alu_op); end
      n_cmp++; if (grant_id !== 1'b0) begin n_err++; $display("FAIL rst_grant_id got=%b exp=0", grant_id); end
      rst_n = 1'b1;
      #1;
      n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL rst_first_grant got=%b exp=01", req_ready); end
      req_valid = 2'b00;
      tick();
   endtask

   task automatic single_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] op, input logic [31:0] exp_d);
      set_req(0, a, b, op);
      req_valid = 2'b01;
      #1;
      n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL %s_req_ready got=%b exp=01", nm, req_ready); end
      tick();
      req_valid = 2'b00;
      n_cmp++; if ({alu_a, alu_b, alu_op} !== {a, b, op}) begin n_err++; $display("FAIL %s_alu_in got=%h/%h/%h exp=%h/%h/%h", nm, alu_a, alu_b, alu_op, a, b, op); end
      n_cmp++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL %s_rsp_early got=%b exp=00", nm, rsp_valid); end
      tick();
      n_cmp++; if (rsp_valid !== 2'b01) begin n_err++; $display("FAIL %s_rsp_valid got=%b exp=01", nm, rsp_valid); end
      n_cmp++; if (rsp_data !== exp_d) begin n_err++; $display("FAIL %s_rsp_data got=%h exp=%h", nm, rsp_data, exp_d); end
      n_cmp++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL %s_rsp_err got=%b exp=0", nm, rsp_err); end
      rsp_ready = 2'b01;
      tick();
      rsp_ready = 2'b00;
      n_cmp++; if (busy !== 1'b0 || rsp_valid !== 2'b00) begin n_err++; $display("FAIL %s_back_idle got busy=%b rsp_valid=%b exp=0/00", nm, busy, rsp_valid); end
   endtask

   task automatic test_single_op();
      single_op("single", 32'd5, 32'd3, 4'd1, 32'd2);
   endtask

   task automatic test_round_robin();
      logic [1:0]  exp_oh;
      logic [31:0] exp_d;
      apply_reset();
      set_req(0, 32'd1, 32'd1, 4'd0);
      set_req(1, 32'hFFFF_FFFF, 32'd0, 4'd8);
      req_valid = 2'b11;
      rsp_ready = 2'b11;
      for (int i = 0; i < 4; i++) begin
         exp_oh = (i % 2 == 0) ? 2'b01 : 2'b10;
         exp_d  = (i % 2 == 0) ? 32'd2 : 32'd1;
         #1;
         n_cmp++; if (req_ready !== exp_oh) begin n_err++; $display("FAIL rr_grant%0d got=%b exp=%b", i, req_ready, exp_oh); end
         tick();
         tick();
         n_cmp++; if (rsp_valid !== exp_oh) begin n_err++; $display("FAIL rr_rsp_valid%0d got=%b exp=%b", i, rsp_valid, exp_oh); end
         n_cmp++; if (rsp_data !== exp_d) begin n_err++; $display("FAIL rr_rsp_data%0d got=%h exp=%h", i, rsp_data, exp_d); end
         n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL rr_no_grant_in_resp%0d got=%b exp=00", i, req_ready); end
         tick();
      end
      req_valid = 2'b00;
      rsp_ready = 2'b00;
      tick();
   endtask

   task automatic test_backpressure();
      set_req(0, 32'h0000_F0F0, 32'h0000_0FF0, 4'd4);
      req_valid = 2'b01;
      tick();
      req_valid = 2'b00;
      tick();
      req_valid = 2'b11;
      rsp_ready = 2'b10;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_cmp++; if (rsp_valid !== 2'b01 || rsp_data !== 32'h0000_FF00) begin n_err++; $display("FAIL bp_hold%0d got=%b/%h exp=01/0000ff00", i, rsp_valid, rsp_data); end
         n_cmp++; if (req_ready !== 2'b00 || busy !== 1'b1) begin n_err++; $display("FAIL bp_stall%0d got ready=%b busy=%b exp=00/1", i, req_ready, busy); end
         tick();
      end
      req_valid = 2'b00;
      rsp_ready = 2'b01;
      tick();
      rsp_ready = 2'b00;
      n_cmp++; if (busy !== 1'b0 || rsp_valid !== 2'b00) begin n_err++; $display("FAIL bp_release got busy=%b rsp_valid=%b exp=0/00", busy, rsp_valid); end
   endtask

   task automatic test_illegal_op();
      set_req(1, 32'd7, 32'd9, 4'd12);
      req_valid = 2'b10;
      #1;
      n_cmp++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL ill_req_ready got=%b exp=10", req_ready); end
      tick();
      req_valid = 2'b00;
      n_cmp++; if (alu_op !== 4'd12) begin n_err++; $display("FAIL ill_alu_op got=%h exp=c", alu_op); end
      tick();
      n_cmp++; if (rsp_valid !== 2'b10 || grant_id !== 1'b1) begin n_err++; $display("FAIL ill_rsp_valid got=%b gid=%b exp=10/1", rsp_valid, grant_id); end
      n_cmp++; if (rsp_data !== 32'd0 || rsp_err !== 1'b1) begin n_err++; $display("FAIL ill_rsp got=%h/%b exp=0/1", rsp_data, rsp_err); end
      rsp_ready = 2'b10;
      tick();
      rsp_ready = 2'b00;
   endtask

   task automatic test_reset_mid_op();
      set_req(0, 32'h8000_0000, 32'd4, 4'd7);
      req_valid = 2'b01;
      tick();
      req_valid = 2'b00;
      rsp_ready = 2'b11;
      n_cmp++; if (busy !== 1'b1 || alu_op !== 4'd7) begin n_err++; $display("FAIL mid_exec got busy=%b op=%h exp=1/7", busy, alu_op); end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      n_cmp++; if (busy !== 1'b0 || alu_a !== 32'd0 || alu_op !== 4'd0) begin n_err++; $display("FAIL mid_cleared got busy=%b a=%h op=%h exp=0/0/0", busy, alu_a, alu_op); end
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL mid_no_rsp%0d got=%b exp=00", i, rsp_valid); end
         tick();
      end
      rsp_ready = 2'b00;
      single_op("after_rst", 32'd5, 32'd3, 4'd1, 32'd2);
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      req_op    = '0;
      rsp_ready = '0;
      test_reset();
      test_single_op();
      test_round_robin();
      test_backpressure();
      test_illegal_op();
      test_reset_mid_op();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
